fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch stage for the RV32I pipeline. It replaces the bare PC register plus IF/ID latch with a PC generator driving the synchronous instruction SRAM and a DEPTH-entry instruction queue. A valid/ready handshake decouples fetch from decode, so decode stalls no longer freeze the SRAM request. Branch/jump redirects from the execute stage flush the queue and any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `ADDR_W`, default 16: IM address width.
- `CNT_W`, default $clog2(DEPTH+1): width of `count`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `im_req` out 1: a fetch is issued this cycle.
- `im_addr` out ADDR_W: IM read address, equal to `fetch_pc[ADDR_W-1:0]`.
- `im_rdata` in 32: IM read data, valid one cycle after `im_req`.
- `redirect` in 1: taken branch/jump in E; flush and refetch.
- `redirect_pc` in 32: target address; bits [1:0] are ignored and treated as 0.
- `d_valid` out 1: queue head holds an instruction.
- `d_ready` in 1: decode accepts the head this cycle.
- `d_pc` out 32: PC of the head entry.
- `d_inst` out 32: instruction of the head entry.
- `count` out CNT_W: number of occupied entries.

## Operation
- **State:**
  - `fetch_pc` (32).
  - `inflight` flag plus `inflight_pc`.
  - Circular buffer of DEPTH {pc, inst} entries with `rd_ptr` / `wr_ptr` (log2 DEPTH bits, natural wrap) and `count`.
- **Issue rule:**
  - `im_req = !redirect && (count + inflight < DEPTH)`.
  - A pop in the same cycle does not free a credit, so overflow is impossible by construction.
- **On issue:** `inflight <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^32. With no issue, `inflight <= 0`.
- **Push:** when `inflight == 1` and no `redirect`, write {`inflight_pc`, `im_rdata`} at `wr_ptr`, then increment `wr_ptr`.
- **Pop:** when `d_valid && d_ready` and no `redirect`, increment `rd_ptr`.
- **count:** +1 on push only, −1 on pop only, unchanged when both or neither occur.
- **Outputs:** `d_valid = (count != 0)`. `d_pc` / `d_inst` come combinationally from entry `rd_ptr`.
- **Redirect (highest priority):**
  - Ptrs and `count` go to 0, `inflight <= 0`, and any data returning next cycle is discarded.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`; `im_req` is 0 during the redirect cycle.
  - A pop handshake coinciding with `redirect` is void; decode must also squash on `redirect`.

## Timing
- **Reset values:** `fetch_pc = RESET_PC`, `inflight = 0`, ptrs = 0, `count = 0`, all entries = 0. Hence `d_valid = 0`, `d_pc = 0`, `d_inst = 0`, and `im_addr = RESET_PC[ADDR_W-1:0]`.
  - `im_req` is combinational, so it is 1 as soon as reset deasserts, because `count + inflight = 0 < DEPTH`.
  - Reset mid-operation discards all entries and the in-flight fetch immediately.
- **Fetch-to-decode latency:** 2 cycles.
  - Request in cycle T, data in T+1, written at the end of T+1, `d_valid` in T+2.
- **Redirect latency:** `redirect` in T, request to the target in T+1, target at the queue head with `d_valid` in T+3.
- **Throughput:** with `d_ready` held high, one instruction per cycle in steady state (`count` ≤ 1, `inflight` = 1).
- **Full queue:** `count == DEPTH` holds `im_req` low. Draining one entry re-enables issue the cycle after the pop.

## Test plan
- **Reset then fill, DEPTH=4:** reset low for 3 cycles, then `d_ready = 0`.
  - Requests go out at PC 0, 4, 8, 12, then `im_req` stays 0.
  - `count = 4`, `d_pc = 0`, `d_inst = mem[0]`.
- **Streaming:** `d_ready = 1` from reset, IM word i = 0x1000 + i.
  - From cycle 2 after reset, `d_valid = 1` every cycle.
  - `d_pc` goes 0, 4, 8, … with `d_inst` 0x1000, 0x1001, …; no bubbles.
- **Redirect with full queue and inflight:** fill, pop one, then assert `redirect` with `redirect_pc = 0x203`.
  - `count = 0` next cycle and `im_addr = 0x200` with `im_req = 1`.
  - Next `d_pc = 0x200`, three cycles after `redirect`; no stale entry is delivered.
- **Decode backpressure toggle:** `d_ready` alternates 1/0.
  - Delivered PCs are strictly sequential, with no loss or duplication.
  - `count` never exceeds 4.
- **Simultaneous push and pop at `count = 2`:** `count` stays 2 and both pointers advance.
- **Reset mid-stream:** drop `rst` with `count = 3`.
  - `d_valid = 0` asynchronously.
  - After release, fetch restarts at `RESET_PC` and the first delivered instruction is `mem[RESET_PC]`.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generator driving a synchronous IM plus a DEPTH-entry
// {pc, inst} queue handed to decode over a valid/ready handshake.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              im_req,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [31:0]       im_rdata,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [31:0]       d_pc,
   output logic [31:0]       d_inst,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [31:0]      r_fetch_pc;
   logic             r_inflight;
   logic [31:0]      r_inflight_pc;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_pc_mem   [DEPTH];
   logic [31:0]      r_inst_mem [DEPTH];

   logic w_issue;
   logic w_push;
   logic w_pop;
   logic w_unused_rpc;

   // Credits cover both stored entries and the fetch still in flight, so a push never overflows.
   assign w_issue      = !redirect && ((32'(r_count) + 32'(r_inflight)) < DEPTH);
   assign w_push       = r_inflight && !redirect;
   assign w_pop        = d_valid && d_ready && !redirect;
   assign w_unused_rpc = ^redirect_pc[1:0];

   assign im_req  = w_issue;
   assign im_addr = r_fetch_pc[ADDR_W-1:0];
   assign d_valid = (r_count != '0);
   assign d_pc    = r_pc_mem[r_rd_ptr];
   assign d_inst  = r_inst_mem[r_rd_ptr];
   assign count   = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_pc_mem[PTR_W'(i)]   <= '0;
            r_inst_mem[PTR_W'(i)] <= '0;
         end
      end else if (redirect) begin
         // Returning data next cycle is dropped because r_inflight is cleared here.
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
            r_inst_mem[r_wr_ptr] <= im_rdata;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, then queue-model-checked streaming,
// backpressure, random and mid-stream reset sequences.
module tb_fetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              im_req;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_rdata = 32'h0;
   logic              redirect = 1'b0;
   logic [31:0]       redirect_pc = 32'h0;
   logic              d_valid;
   logic              d_ready = 1'b0;
   logic [31:0]       d_pc;
   logic [31:0]       d_inst;
   logic [CNT_W-1:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_queue #(
      .RESET_PC(32'h0000_0000),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_rdata   (im_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .d_valid    (d_valid),
      .d_ready    (d_ready),
      .d_pc       (d_pc),
      .d_inst     (d_inst),
      .count      (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'h1000 + {18'b0, a[15:2]};
   endfunction

   // Synchronous IM: data for a request shows up one cycle later; junk otherwise.
   always @(posedge clk) im_rdata <= im_req ? mem_word(im_addr) : $urandom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: a plain queue of fetched {pc, inst} plus the one outstanding fetch.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   bit          m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_fpc;

   task automatic model_reset();
      mq.delete();
      m_pend    = 1'b0;
      m_pend_pc = 32'h0;
      m_fpc     = 32'h0;
   endtask

   task automatic model_cycle(input bit dr, input bit rd, input logic [31:0] rpc);
      bit   exp_req;
      ent_t e;
      d_ready     = dr;
      redirect    = rd;
      redirect_pc = rpc;
      #2;
      exp_req = !rd && ((mq.size() + (m_pend ? 1 : 0)) < DEPTH);
      check("im_req", 32'(im_req), 32'(exp_req));
      check("im_addr", 32'(im_addr), {16'h0, m_fpc[15:0]});
      check("d_valid", 32'(d_valid), 32'(mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      if (mq.size() != 0) begin
         check("d_pc", d_pc, mq[0].pc);
         check("d_inst", d_inst, mq[0].inst);
      end
      if (rd) begin
         mq.delete();
         m_pend = 1'b0;
         m_fpc  = {rpc[31:2], 2'b00};
      end else begin
         if (dr && mq.size() != 0) void'(mq.pop_front());
         if (m_pend) begin
            e.pc   = m_pend_pc;
            e.inst = mem_word(m_pend_pc[15:0]);
            mq.push_back(e);
         end
         m_pend = exp_req;
         if (exp_req) begin
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      redirect = 1'b0;
      d_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_d_valid", 32'(d_valid), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_d_pc", d_pc, 32'h0);
      check("rst_d_inst", d_inst, 32'h0);
      check("rst_im_addr", 32'(im_addr), 32'h0);
      rst = 1'b1;
      #1;
      check("rst_im_req", 32'(im_req), 32'h1);
      model_reset();
   endtask

   typedef struct {
      bit          dr;
      bit          rd;
      logic [31:0] rpc;
      bit          req;
      logic [15:0] addr;
      bit          valid;
      int          cnt;
      logic [31:0] pc;
   } vec_t;

   function automatic vec_t mk(input bit dr, input bit rd, input logic [31:0] rpc, input bit req,
                               input logic [15:0] addr, input bit valid, input int cnt,
                               input logic [31:0] pc);
      vec_t v;
      v.dr = dr; v.rd = rd; v.rpc = rpc; v.req = req;
      v.addr = addr; v.valid = valid; v.cnt = cnt; v.pc = pc;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      // Fill with decode stalled, pop one, redirect with a fetch in flight, then push+pop at 2.
      tbl[0]  = mk(0, 0, 32'h0,   1, 16'h0000, 0, 0, 32'h0);
      tbl[1]  = mk(0, 0, 32'h0,   1, 16'h0004, 0, 0, 32'h0);
      tbl[2]  = mk(0, 0, 32'h0,   1, 16'h0008, 1, 1, 32'h0);
      tbl[3]  = mk(0, 0, 32'h0,   1, 16'h000C, 1, 2, 32'h0);
      tbl[4]  = mk(0, 0, 32'h0,   0, 16'h0010, 1, 3, 32'h0);
      tbl[5]  = mk(0, 0, 32'h0,   0, 16'h0010, 1, 4, 32'h0);
      tbl[6]  = mk(0, 0, 32'h0,   0, 16'h0010, 1, 4, 32'h0);
      tbl[7]  = mk(1, 0, 32'h0,   0, 16'h0010, 1, 4, 32'h0);
      tbl[8]  = mk(0, 0, 32'h0,   1, 16'h0010, 1, 3, 32'h4);
      tbl[9]  = mk(0, 1, 32'h203, 0, 16'h0014, 1, 3, 32'h4);
      tbl[10] = mk(0, 0, 32'h0,   1, 16'h0200, 0, 0, 32'h0);
      tbl[11] = mk(0, 0, 32'h0,   1, 16'h0204, 0, 0, 32'h0);
      tbl[12] = mk(0, 0, 32'h0,   1, 16'h0208, 1, 1, 32'h200);
      tbl[13] = mk(1, 0, 32'h0,   1, 16'h020C, 1, 2, 32'h200);
      tbl[14] = mk(1, 0, 32'h0,   1, 16'h0210, 1, 2, 32'h204);
      tbl[15] = mk(0, 0, 32'h0,   1, 16'h0214, 1, 2, 32'h208);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         d_ready     = tbl[i].dr;
         redirect    = tbl[i].rd;
         redirect_pc = tbl[i].rpc;
         #2;
         check($sformatf("vec%0d_im_req", i), 32'(im_req), 32'(tbl[i].req));
         check($sformatf("vec%0d_im_addr", i), 32'(im_addr), {16'h0, tbl[i].addr});
         check($sformatf("vec%0d_d_valid", i), 32'(d_valid), 32'(tbl[i].valid));
         check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         if (tbl[i].valid) begin
            check($sformatf("vec%0d_d_pc", i), d_pc, tbl[i].pc);
            check($sformatf("vec%0d_d_inst", i), d_inst, mem_word(tbl[i].pc[15:0]));
         end
         @(posedge clk);
         #1;
      end

      // Streaming with decode always ready.
      do_reset();
      for (int i = 0; i < 20; i++) model_cycle(1'b1, 1'b0, 32'h0);

      // Alternating decode backpressure.
      for (int i = 0; i < 40; i++) model_cycle(i[0], 1'b0, 32'h0);

      // Random ready/redirect traffic.
      for (int i = 0; i < 400; i++) begin
         model_cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
      end

      // Reset mid-stream once three entries are queued.
      do_reset();
      for (int i = 0; i < 20 && mq.size() != 3; i++) model_cycle(1'b0, 1'b0, 32'h0);
      check("midrst_reach_count3", 32'(mq.size()), 32'h3);
      check("midrst_pre_count", 32'(count), 32'h3);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_async_d_valid", 32'(d_valid), 32'h0);
      check("midrst_async_count", 32'(count), 32'h0);
      do_reset();
      for (int i = 0; i < 10; i++) model_cycle(1'b1, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
